pre_proc_frame_ctrl: RTL
========================

// Module: pre_proc_frame_ctrl
// PURPOSE
//  Frame sequencer wrapped around the G.729 pre-processor.
//  - On start, walks one L_FRAME block of raw input speech: reads each sample from the input RAM,
//    drives it to the pre-processor, waits for its done, and writes the filtered sample into the
//    new_speech RAM for LPC analysis.
//  - Pulses done after the last write.
//  - Sits between the input sample buffer and the pre-processor; owns all memory traffic for it.
// PARAMETERS
//  L_FRAME   80     samples per frame
//  ADDR_W    11     RAM address width
//  IN_BASE   0      input RAM address of sample 0
//  OUT_BASE  160    new_speech RAM address of filtered sample 0
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       synchronous, active-high
//  start       in   1       begin one frame; sampled in IDLE only
//  memInAddr   out  ADDR_W  input RAM read address
//  memIn       in   16      input RAM read data, valid 1 cycle after memInAddr
//  ppReady     out  1       one-cycle request to pre-processor
//  ppXn        out  16      sample to pre-processor; held stable from ppReady until ppDone
//  ppYn        in   16      filtered sample from pre-processor, valid when ppDone=1
//  ppDone      in   1       pre-processor completion strobe
//  memOutAddr  out  ADDR_W  new_speech RAM write address
//  memOut      out  16      new_speech RAM write data
//  memWrite    out  1       new_speech RAM write enable, one cycle per sample
//  done        out  1       one-cycle strobe: frame finished
// BEHAVIOUR
//  Reset (synchronous)
//   - State IDLE; sample counter i=0.
//   - All outputs 0, except memInAddr=IN_BASE.
//   - Asserting reset mid-frame aborts the frame immediately. No further writes or done.
//   - The pre-processor shares reset, so its filter memories also clear.
//  State machine (registered state, one transition per clk)
//   - IDLE:  start=1 -> RD, i=0; otherwise stay.
//   - RD:    memInAddr=IN_BASE+i -> LATCH.
//   - LATCH: ppXn<=memIn -> REQ.
//   - REQ:   ppReady=1 for exactly this cycle -> WAIT.
//   - WAIT:  hold ppXn; on ppDone=1 capture ppYn -> WR. ppDone in REQ or IDLE is ignored.
//   - WR:    memWrite=1, memOutAddr=OUT_BASE+i, memOut=captured yn.
//            If i==L_FRAME-1 -> FIN; otherwise i<=i+1 -> RD.
//   - FIN:   done=1 -> IDLE.
//  Timing and handshake
//   - Per-sample cycles = 4 + P, where P = cycles from ppReady to ppDone inclusive.
//   - Frame latency from start to done = L_FRAME*(4+P) + 1.
//   - Exactly L_FRAME memWrite pulses per frame, at strictly increasing addresses, no gaps.
//   - start while not IDLE is ignored; there is no queueing.
//   - start asserted in FIN is also ignored. A new frame needs start while in IDLE.
//   - Filter state (y1, y2, x1, x2) lives in the pre-processor and persists across frames.
//     This block never resets it, except through reset.
//  Widths and wrap
//   - i is $clog2(L_FRAME) bits.
//   - Address sums are ADDR_W bits and wrap modulo 2^ADDR_W. No saturation, no error flag.
//  Registered outputs
//   - memOut, memOutAddr, ppXn and memInAddr are registered.
//   - memInAddr holds its last value outside RD.
// CONFIGURATION
//  PP_CLIP_COUNT_EN
//   - Defined: adds output clipCount [7:0]. Clears on start accepted and on reset.
//     Increments in WR when the captured yn is 16'h7FFF or 16'h8000. Saturates at 255.
//     Valid when done pulses; holds until the next start.
//   - Undefined: port and logic absent; all other behaviour identical.
// TESTING
//  Bench uses a pre-processor stub with P programmable, responding yn = xn + 1.
//  1. Reset, input RAM[k]=k, P=5, start pulse
//     -> 80 writes, memOutAddr 160..239, data 1..80; done at cycle 80*9+1=721.
//  2. reset asserted on the 10th memWrite cycle
//     -> that write completes; all outputs 0 next cycle; no done; next start writes from addr 160.
//  3. start held high through the frame and during FIN
//     -> exactly one frame and one done; returns to IDLE.
//  4. Stub with P varying 2..20 randomly
//     -> ppXn stable throughout every WAIT; one ppReady per sample; 80 writes in order.
//  5. Real pre-processor, all-zero input, two frames
//     -> every memOut=0; filter state carries over (second frame output matches C model).
//  6. PP_CLIP_COUNT_EN; stub returns 7FFF for samples 0..2 and 8000 for sample 79
//     -> clipCount=4 at done; cleared at next start.

Source files
------------

// File: rtl/pre_proc_frame_ctrl_if.sv
// Bus between the frame sequencer, its input/new_speech sample RAMs and the G.729 pre-processor.
// The master side is the sequencer; the slave side is the RAMs plus pre-processor.
interface pre_proc_frame_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] memInAddr;
  logic [15:0]       memIn;
  logic              ppReady;
  logic [15:0]       ppXn;
  logic [15:0]       ppYn;
  logic              ppDone;
  logic [ADDR_W-1:0] memOutAddr;
  logic [15:0]       memOut;
  logic              memWrite;

  modport master (
    output memInAddr, ppReady, ppXn, memOutAddr, memOut, memWrite,
    input  memIn, ppYn, ppDone
  );

  modport slave (
    input  memInAddr, ppReady, ppXn, memOutAddr, memOut, memWrite,
    output memIn, ppYn, ppDone
  );
endinterface

// File: rtl/pre_proc_frame_ctrl.sv
// Frame sequencer around the G.729 pre-processor: reads L_FRAME raw samples, filters each, writes new_speech.
// Optional PP_CLIP_COUNT_EN adds clipCount, the number of saturated filter outputs in the last frame.
module pre_proc_frame_ctrl #(
  parameter int L_FRAME  = 80,
  parameter int ADDR_W   = 11,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 160
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  pre_proc_frame_ctrl_if.master bus,
  output logic                 done
`ifdef PP_CLIP_COUNT_EN
  ,
  output logic [7:0]           clipCount
`endif
);

  localparam int                IDX_W     = $clog2(L_FRAME);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(L_FRAME - 1);
  localparam logic [ADDR_W-1:0] IN_BASE_A = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LATCH,
    REQ,
    WAIT,
    WR,
    FIN
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;

  // Outputs are loaded on the transition into the state that owns them. The read address
  // is therefore already on the RAM during RD, so memIn is valid when LATCH captures it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      bus.memInAddr  <= IN_BASE_A;
      bus.ppReady    <= 1'b0;
      bus.ppXn       <= '0;
      bus.memOutAddr <= '0;
      bus.memOut     <= '0;
      bus.memWrite   <= 1'b0;
      done           <= 1'b0;
    end else begin
      bus.ppReady  <= 1'b0;
      bus.memWrite <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx           <= '0;
            bus.memInAddr <= IN_BASE_A;
            state         <= RD;
          end
        end
        RD: begin
          state <= LATCH;
        end
        LATCH: begin
          bus.ppXn <= bus.memIn;
          state    <= REQ;
        end
        REQ: begin
          bus.ppReady <= 1'b1;
          state       <= WAIT;
        end
        WAIT: begin
          if (bus.ppDone) begin
            bus.memOut     <= bus.ppYn;
            bus.memOutAddr <= OUT_BASE_A + ADDR_W'(idx);
            bus.memWrite   <= 1'b1;
            state          <= WR;
          end
        end
        WR: begin
          if (idx == LAST_IDX) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            idx           <= idx + IDX_W'(1);
            bus.memInAddr <= IN_BASE_A + ADDR_W'(idx + IDX_W'(1));
            state         <= RD;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef PP_CLIP_COUNT_EN
  // memOut holds the captured yn throughout WR, so the saturation test looks at it directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      clipCount <= '0;
    end else if (state == IDLE && start) begin
      clipCount <= '0;
    end else if (state == WR && (bus.memOut == 16'h7FFF || bus.memOut == 16'h8000)
                 && clipCount != 8'hFF) begin
      clipCount <= clipCount + 8'd1;
    end
  end
`endif

endmodule
